// File: rtl/cpu_control_pkg.sv
// Shared decode constants for the single-cycle RV32I-subset core:
// opcode fields, ALU operation codes, immediate formats and write-back sources.
package cpu_defs;

    localparam logic [4:0] OP_R      = 5'b01100;
    localparam logic [4:0] OP_I      = 5'b00100;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_LUI    = 5'b01101;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_SRL = 3'b101;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_MEM  = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;
    localparam logic [1:0] WB_UIMM = 2'b11;

    // How the ALU operation is chosen for an instruction class.
    typedef enum logic [1:0] {
        ALU_CLS_ADD,
        ALU_CLS_SUB,
        ALU_CLS_R,
        ALU_CLS_I
    } alu_class_t;

endpackage

// File: rtl/cpu_control_alu_decoder.sv
// ALU operation decoder: maps instruction class plus funct3/funct7[5] to an
// ALU_Control code and flags funct combinations the core does not implement.
module alu_decoder
    import cpu_defs::*;
(
    input  alu_class_t op_class,
    input  logic [2:0] fun3,
    input  logic       fun7,
    output logic [2:0] alu_control,
    output logic       funct_illegal
);

    always_comb begin
        alu_control   = ALU_ADD;
        funct_illegal = 1'b0;
        unique case (op_class)
            ALU_CLS_ADD: alu_control = ALU_ADD;
            ALU_CLS_SUB: alu_control = ALU_SUB;
            ALU_CLS_R: begin
                case ({fun7, fun3})
                    4'b0000: alu_control = ALU_ADD;
                    4'b1000: alu_control = ALU_SUB;
                    4'b0111: alu_control = ALU_AND;
                    4'b0110: alu_control = ALU_OR;
                    4'b0100: alu_control = ALU_XOR;
                    4'b0010: alu_control = ALU_SLT;
                    4'b0101: alu_control = ALU_SRL;
                    default: funct_illegal = 1'b1;
                endcase
            end
            ALU_CLS_I: begin
                // Fun7 is an immediate bit here except for shifts, where it selects SRA.
                case (fun3)
                    3'b000:  alu_control = ALU_ADD;
                    3'b111:  alu_control = ALU_AND;
                    3'b110:  alu_control = ALU_OR;
                    3'b100:  alu_control = ALU_XOR;
                    3'b010:  alu_control = ALU_SLT;
                    3'b101: begin
                        if (!fun7) alu_control = ALU_SRL;
                        else       funct_illegal = 1'b1;
                    end
                    default: funct_illegal = 1'b1;
                endcase
            end
            default: funct_illegal = 1'b1;
        endcase
        if (funct_illegal) alu_control = ALU_ADD;
    end

endmodule

// File: rtl/cpu_control.sv
// Main control decoder of the single-cycle core: combinational datapath
// selects and enables, plus a sticky registered illegal-instruction flag.
module cpu_control
    import cpu_defs::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] OPcode,
    input  logic [2:0] Fun3,
    input  logic       Fun7,
    input  logic       MIO_ready,
    output logic [1:0] ImmSel,
    output logic       ALUSrc_B,
    output logic [1:0] MemtoReg,
    output logic       Jump,
    output logic       Branch,
    output logic       InverseBranch,
    output logic       RegWrite,
    output logic       MemRW,
    output logic [2:0] ALU_Control,
    output logic       CPU_MIO,
    output logic       ill_inst
);

    alu_class_t op_class;
    logic [2:0] alu_dec;
    logic       funct_illegal;
    logic       op_illegal;
    logic       illegal;

    logic [1:0] imm_sel_d;
    logic       alu_src_b_d;
    logic [1:0] mem_to_reg_d;
    logic       jump_d;
    logic       branch_d;
    logic       inv_branch_d;
    logic       reg_write_d;
    logic       mem_rw_d;
    logic       cpu_mio_d;

    // MIO_ready is reserved for a future stalling memory interface.
    logic unused_mio_ready;
    assign unused_mio_ready = MIO_ready;

    always_comb begin
        case (OPcode)
            OP_R:      op_class = ALU_CLS_R;
            OP_I:      op_class = ALU_CLS_I;
            OP_BRANCH: op_class = ALU_CLS_SUB;
            default:   op_class = ALU_CLS_ADD;
        endcase
    end

    alu_decoder u_alu_decoder (
        .op_class      (op_class),
        .fun3          (Fun3),
        .fun7          (Fun7),
        .alu_control   (alu_dec),
        .funct_illegal (funct_illegal)
    );

    always_comb begin
        imm_sel_d    = IMM_I;
        alu_src_b_d  = 1'b0;
        mem_to_reg_d = WB_ALU;
        jump_d       = 1'b0;
        branch_d     = 1'b0;
        inv_branch_d = 1'b0;
        reg_write_d  = 1'b0;
        mem_rw_d     = 1'b0;
        cpu_mio_d    = 1'b0;
        op_illegal   = 1'b0;
        case (OPcode)
            OP_R: begin
                reg_write_d = 1'b1;
            end
            OP_I: begin
                alu_src_b_d = 1'b1;
                reg_write_d = 1'b1;
            end
            OP_LOAD: begin
                if (Fun3 == 3'b010) begin
                    alu_src_b_d  = 1'b1;
                    mem_to_reg_d = WB_MEM;
                    reg_write_d  = 1'b1;
                    cpu_mio_d    = 1'b1;
                end else begin
                    op_illegal = 1'b1;
                end
            end
            OP_STORE: begin
                if (Fun3 == 3'b010) begin
                    imm_sel_d   = IMM_S;
                    alu_src_b_d = 1'b1;
                    mem_rw_d    = 1'b1;
                    cpu_mio_d   = 1'b1;
                end else begin
                    op_illegal = 1'b1;
                end
            end
            OP_BRANCH: begin
                if (Fun3 == 3'b000 || Fun3 == 3'b001) begin
                    imm_sel_d    = IMM_B;
                    branch_d     = 1'b1;
                    inv_branch_d = Fun3[0];
                end else begin
                    op_illegal = 1'b1;
                end
            end
            OP_JAL: begin
                imm_sel_d    = IMM_J;
                jump_d       = 1'b1;
                mem_to_reg_d = WB_PC4;
                reg_write_d  = 1'b1;
            end
            OP_LUI: begin
                mem_to_reg_d = WB_UIMM;
                reg_write_d  = 1'b1;
            end
            default: op_illegal = 1'b1;
        endcase
    end

    assign illegal = op_illegal | funct_illegal;

    // An illegal encoding collapses every output to its default so it runs as a NOP.
    always_comb begin
        ImmSel        = illegal ? IMM_I   : imm_sel_d;
        ALUSrc_B      = illegal ? 1'b0    : alu_src_b_d;
        MemtoReg      = illegal ? WB_ALU  : mem_to_reg_d;
        Jump          = illegal ? 1'b0    : jump_d;
        Branch        = illegal ? 1'b0    : branch_d;
        InverseBranch = illegal ? 1'b0    : inv_branch_d;
        RegWrite      = illegal ? 1'b0    : reg_write_d;
        MemRW         = illegal ? 1'b0    : mem_rw_d;
        CPU_MIO       = illegal ? 1'b0    : cpu_mio_d;
        ALU_Control   = illegal ? ALU_ADD : alu_dec;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ill_inst <= '0;
        end else if (illegal) begin
            ill_inst <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cpu_control.sv
// Self-checking bench for cpu_control: a table-driven instruction model
// checked every cycle, plus directed literal checks from known encodings.
module tb_cpu_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] OPcode;
    logic [2:0] Fun3;
    logic       Fun7;
    logic       MIO_ready;
    logic [1:0] ImmSel;
    logic       ALUSrc_B;
    logic [1:0] MemtoReg;
    logic       Jump;
    logic       Branch;
    logic       InverseBranch;
    logic       RegWrite;
    logic       MemRW;
    logic [2:0] ALU_Control;
    logic       CPU_MIO;
    logic       ill_inst;

    cpu_control dut (
        .clk           (clk),
        .rst           (rst),
        .OPcode        (OPcode),
        .Fun3          (Fun3),
        .Fun7          (Fun7),
        .MIO_ready     (MIO_ready),
        .ImmSel        (ImmSel),
        .ALUSrc_B      (ALUSrc_B),
        .MemtoReg      (MemtoReg),
        .Jump          (Jump),
        .Branch        (Branch),
        .InverseBranch (InverseBranch),
        .RegWrite      (RegWrite),
        .MemRW         (MemRW),
        .ALU_Control   (ALU_Control),
        .CPU_MIO       (CPU_MIO),
        .ill_inst      (ill_inst)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] imm;
        logic       srcb;
        logic [1:0] m2r;
        logic       jump;
        logic       branch;
        logic       inv;
        logic       regw;
        logic       memrw;
        logic [2:0] alu;
        logic       mio;
    } ctl_t;

    typedef struct {
        logic [4:0] op;
        logic [2:0] f3;
        logic       f3_any;
        logic       f7;
        logic       f7_any;
        ctl_t       c;
    } row_t;

    row_t tbl[$];
    ctl_t got;
    logic exp_ill;
    logic check_en = 1'b0;
    int   errors = 0;
    int   checks = 0;

    assign got = {ImmSel, ALUSrc_B, MemtoReg, Jump, Branch, InverseBranch,
                  RegWrite, MemRW, ALU_Control, CPU_MIO};

    function automatic ctl_t mk(input logic [1:0] imm, input logic srcb,
                                input logic [1:0] m2r, input logic jump,
                                input logic branch, input logic inv,
                                input logic regw, input logic memrw,
                                input logic [2:0] alu, input logic mio);
        ctl_t c;
        c = {imm, srcb, m2r, jump, branch, inv, regw, memrw, alu, mio};
        return c;
    endfunction

    task automatic add_row(input logic [4:0] op, input logic [2:0] f3, input logic f3_any,
                           input logic f7, input logic f7_any, input ctl_t c);
        row_t r;
        r.op = op; r.f3 = f3; r.f3_any = f3_any; r.f7 = f7; r.f7_any = f7_any; r.c = c;
        tbl.push_back(r);
    endtask

    // Returns 1 when the fields name a supported instruction; c gets its controls.
    function automatic logic model(input logic [4:0] op, input logic [2:0] f3,
                                   input logic f7, output ctl_t c);
        c = mk(2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 3'b010, 0);
        foreach (tbl[i]) begin
            if (tbl[i].op == op && (tbl[i].f3_any || tbl[i].f3 == f3)
                && (tbl[i].f7_any || tbl[i].f7 == f7)) begin
                c = tbl[i].c;
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            ctl_t exp_c;
            void'(model(OPcode, Fun3, Fun7, exp_c));
            chk("ctl_model", 32'(got), 32'(exp_c));
            chk("ill_model", 32'(ill_inst), 32'(exp_ill));
        end
    end

    task automatic apply_fields(input logic [4:0] op, input logic [2:0] f3, input logic f7,
                                input logic r, input logic mio);
        ctl_t dummy;
        @(posedge clk);
        exp_ill  = rst ? 1'b0 : (exp_ill | ~model(OPcode, Fun3, Fun7, dummy));
        check_en = 1'b1;
        #1;
        OPcode = op; Fun3 = f3; Fun7 = f7; rst = r; MIO_ready = mio;
        @(negedge clk);
        #1;
    endtask

    task automatic apply(input logic [31:0] inst, input logic r, input logic mio);
        apply_fields(inst[6:2], inst[14:12], inst[30], r, mio);
    endtask

    localparam logic [31:0] I_ADD = 32'h003100B3;
    localparam logic [31:0] I_SUB = 32'h403100B3;
    localparam logic [31:0] I_LW  = 32'h00412083;
    localparam logic [31:0] I_SW  = 32'h00112223;
    localparam logic [31:0] I_BEQ = 32'h00208463;
    localparam logic [31:0] I_BNE = 32'h00209463;
    localparam logic [31:0] I_JAL = 32'h008000EF;
    localparam logic [31:0] I_LUI = 32'h123450B7;
    localparam logic [31:0] I_BAD = 32'hFFFFFFFF;

    initial begin
        ctl_t lw_ctl;
        row_t rr;
        // R-type
        add_row(5'b01100, 3'b000, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 1, 0, 3'b010, 0));
        add_row(5'b01100, 3'b000, 0, 1, 0, mk(0, 0, 0, 0, 0, 0, 1, 0, 3'b110, 0));
        add_row(5'b01100, 3'b111, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 1, 0, 3'b000, 0));
        add_row(5'b01100, 3'b110, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 1, 0, 3'b001, 0));
        add_row(5'b01100, 3'b100, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 1, 0, 3'b011, 0));
        add_row(5'b01100, 3'b010, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 1, 0, 3'b111, 0));
        add_row(5'b01100, 3'b101, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 1, 0, 3'b101, 0));
        // I-ALU
        add_row(5'b00100, 3'b000, 0, 0, 1, mk(0, 1, 0, 0, 0, 0, 1, 0, 3'b010, 0));
        add_row(5'b00100, 3'b111, 0, 0, 1, mk(0, 1, 0, 0, 0, 0, 1, 0, 3'b000, 0));
        add_row(5'b00100, 3'b110, 0, 0, 1, mk(0, 1, 0, 0, 0, 0, 1, 0, 3'b001, 0));
        add_row(5'b00100, 3'b100, 0, 0, 1, mk(0, 1, 0, 0, 0, 0, 1, 0, 3'b011, 0));
        add_row(5'b00100, 3'b010, 0, 0, 1, mk(0, 1, 0, 0, 0, 0, 1, 0, 3'b111, 0));
        add_row(5'b00100, 3'b101, 0, 0, 0, mk(0, 1, 0, 0, 0, 0, 1, 0, 3'b101, 0));
        // lw, sw, beq, bne, jal, lui
        add_row(5'b00000, 3'b010, 0, 0, 1, mk(0, 1, 2'b01, 0, 0, 0, 1, 0, 3'b010, 1));
        add_row(5'b01000, 3'b010, 0, 0, 1, mk(2'b01, 1, 0, 0, 0, 0, 0, 1, 3'b010, 1));
        add_row(5'b11000, 3'b000, 0, 0, 1, mk(2'b10, 0, 0, 0, 1, 0, 0, 0, 3'b110, 0));
        add_row(5'b11000, 3'b001, 0, 0, 1, mk(2'b10, 0, 0, 0, 1, 1, 0, 0, 3'b110, 0));
        add_row(5'b11011, 3'b000, 1, 0, 1, mk(2'b11, 0, 2'b10, 1, 0, 0, 1, 0, 3'b010, 0));
        add_row(5'b01101, 3'b000, 1, 0, 1, mk(0, 0, 2'b11, 0, 0, 0, 1, 0, 3'b010, 0));

        exp_ill = 1'b0;
        rst = 1'b1; MIO_ready = 1'b0;
        OPcode = I_ADD[6:2]; Fun3 = I_ADD[14:12]; Fun7 = I_ADD[30];

        // Reset, then directed decodes with hand-derived expectations.
        apply(I_ADD, 1, 0);
        chk("reset_ill", 32'(ill_inst), 0);
        chk("add_regw", 32'(RegWrite), 1);
        chk("add_alu", 32'(ALU_Control), 32'h2);
        chk("add_srcb_m2r", 32'({ALUSrc_B, MemtoReg}), 0);
        chk("add_memctl", 32'({MemRW, CPU_MIO, Branch, Jump, InverseBranch}), 0);
        apply(I_SUB, 0, 0);
        chk("sub_alu", 32'(ALU_Control), 32'h6);
        apply(I_LW, 0, 0);
        chk("lw_ctl", 32'({ImmSel, ALUSrc_B, MemtoReg, RegWrite, MemRW, CPU_MIO}), 32'b00_1_01_1_0_1);
        lw_ctl = got;
        apply(I_LW, 0, 1);
        chk("lw_mio_ready", 32'(got), 32'(lw_ctl));
        apply(I_SW, 0, 0);
        chk("sw_ctl", 32'({ImmSel, ALUSrc_B, RegWrite, MemRW, CPU_MIO}), 32'b01_1_0_1_1);
        apply(I_BEQ, 0, 1);
        chk("beq_ctl", 32'({Branch, InverseBranch, ImmSel, ALU_Control}), 32'b1_0_10_110);
        apply(I_BNE, 0, 0);
        chk("bne_inv", 32'(InverseBranch), 1);
        apply(I_JAL, 0, 0);
        chk("jal_ctl", 32'({Jump, ImmSel, MemtoReg, RegWrite}), 32'b1_11_10_1);
        apply(I_LUI, 0, 0);
        chk("lui_ctl", 32'({MemtoReg, RegWrite}), 32'b11_1);

        // Sticky flag sequence.
        apply(I_BAD, 0, 0);
        chk("bad_enables", 32'({RegWrite, MemRW, CPU_MIO, Jump, Branch}), 0);
        chk("bad_ill_not_yet", 32'(ill_inst), 0);
        apply(I_ADD, 0, 0);
        chk("ill_set", 32'(ill_inst), 1);
        apply(I_ADD, 0, 0);
        chk("ill_sticky", 32'(ill_inst), 1);
        apply(I_ADD, 1, 0);
        apply(I_BAD, 1, 0);
        chk("ill_cleared", 32'(ill_inst), 0);
        apply(I_ADD, 0, 0);
        chk("rst_priority", 32'(ill_inst), 0);

        // Randomized stimulus against the table model.
        for (int n = 0; n < 3000; n++) begin
            logic [4:0] op;
            logic [2:0] f3;
            logic       f7;
            if ($urandom_range(0, 9) < 6) begin
                rr = tbl[$urandom_range(0, tbl.size() - 1)];
                op = rr.op;
                f3 = rr.f3_any ? 3'($urandom) : rr.f3;
                f7 = rr.f7_any ? 1'($urandom) : rr.f7;
            end else begin
                op = 5'($urandom);
                f3 = 3'($urandom);
                f7 = 1'($urandom);
            end
            apply_fields(op, f3, f7, ($urandom_range(0, 15) == 0), 1'($urandom));
        end

        check_en = 1'b0;
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
